spi_slave_cs: RTL

//  SPI peripheral (slave) endpoint with chip select; the far end of the team's SPI master.

---
 rtl/spi_slave_cs.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/spi_slave_cs.sv
// SPI peripheral endpoint: oversampled SCLK/CS/MOSI, byte deserialiser, and MISO serialiser
// fed from a single-entry TX holding register. All four SPI modes are supported.
//   state     | meaning
//   WAIT_HIGH | after reset, wait for cs high so a frame already in flight is ignored
//   IDLE      | cs high, waiting for the cs falling edge
//   LOAD      | one clk: holding register (or FILL_BYTE) into the TX shift register
//   SHIFT     | sample and shift bits until 8 sample edges complete a byte
module spi_slave_cs #(
    parameter int unsigned  SPI_MODE         = 0,
    parameter int unsigned  MAX_BYTES_PER_CS = 2,
    parameter logic [7:0]   FILL_BYTE        = 8'hFF,
    localparam int unsigned CW               = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [7:0]    mosi_byte,
    output logic          mosi_tick,
    output logic [CW-1:0] mosi_count,
    input  logic [7:0]    miso_byte,
    input  logic          miso_tick,
    output logic          miso_ready,
    output logic          underrun,
    output logic          frame_abort,
    input  logic          spi_clk,
    input  logic          spi_mosi,
    input  logic          spi_cs,
    output logic          spi_miso,
    output logic          spi_miso_oe
);
    localparam logic [1:0] MODE = SPI_MODE[1:0];
    localparam logic       CPOL = MODE[1];
    localparam logic       CPHA = MODE[0];

    typedef enum logic [1:0] {WAIT_HIGH, IDLE, LOAD, SHIFT} state_t;

    state_t     state;
    logic [2:0] sclk_sync;
    logic [2:0] cs_sync;
    logic [1:0] mosi_sync;
    logic [3:0] bit_cnt;
    logic [7:0] rx_sr;
    logic [7:0] tx_sr;
    logic [7:0] hold_reg;
    logic [7:0] load_val;
    logic       byte_done;
    logic       fill_pend;
    logic       lead_edge;
    logic       trail_edge;
    logic       sample_edge;
    logic       shift_edge;
    logic       cs_high;
    logic       cs_fall;
    logic       cs_rise;
    logic       mosi_s;
    logic       load_go;

    // cs synchronisers reset low so WAIT_HIGH only leaves on a real, synchronised cs=1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= {3{CPOL}};
            cs_sync   <= 3'b000;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi_clk};
            cs_sync   <= {cs_sync[1:0], spi_cs};
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    always_comb begin
        lead_edge   = (sclk_sync[1] != CPOL) && (sclk_sync[2] == CPOL);
        trail_edge  = (sclk_sync[1] == CPOL) && (sclk_sync[2] != CPOL);
        sample_edge = CPHA ? trail_edge : lead_edge;
        shift_edge  = CPHA ? lead_edge : trail_edge;
        cs_high     = cs_sync[1];
        cs_fall     = !cs_sync[1] && cs_sync[2];
        cs_rise     = cs_sync[1] && !cs_sync[2];
        mosi_s      = mosi_sync[1];
        load_go     = (state == LOAD) && !cs_rise;
        load_val    = miso_ready ? FILL_BYTE : hold_reg;
    end

    // A write coinciding with a LOAD is accepted even when full: LOAD takes the old content.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_reg   <= 8'h00;
            miso_ready <= 1'b1;
        end else if (miso_tick && (miso_ready || load_go)) begin
            hold_reg   <= miso_byte;
            miso_ready <= 1'b0;
        end else if (load_go) begin
            miso_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mosi_count <= '0;
        end else if (cs_high) begin
            mosi_count <= '0;
        end else if (mosi_tick && (mosi_count < CW'(MAX_BYTES_PER_CS))) begin
            mosi_count <= mosi_count + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= WAIT_HIGH;
            bit_cnt     <= 4'd0;
            rx_sr       <= 8'h00;
            tx_sr       <= 8'h00;
            byte_done   <= 1'b0;
            fill_pend   <= 1'b0;
            mosi_byte   <= 8'h00;
            mosi_tick   <= 1'b0;
            underrun    <= 1'b0;
            frame_abort <= 1'b0;
            spi_miso    <= 1'b1;
            spi_miso_oe <= 1'b0;
        end else begin
            mosi_tick   <= 1'b0;
            underrun    <= 1'b0;
            frame_abort <= 1'b0;
            if ((state == LOAD || state == SHIFT) && cs_rise) begin
                state       <= IDLE;
                frame_abort <= (bit_cnt != 4'd0) && !bit_cnt[3];
                bit_cnt     <= 4'd0;
                byte_done   <= 1'b0;
                fill_pend   <= 1'b0;
                rx_sr       <= 8'h00;
                tx_sr       <= 8'h00;
                spi_miso    <= 1'b1;
                spi_miso_oe <= 1'b0;
            end else begin
                case (state)
                    WAIT_HIGH: if (cs_high) state <= IDLE;
                    IDLE:      if (cs_fall) state <= LOAD;
                    LOAD: begin
                        bit_cnt     <= 4'd0;
                        fill_pend   <= miso_ready;
                        spi_miso_oe <= 1'b1;
                        if (!CPHA) begin
                            spi_miso <= load_val[7];
                            tx_sr    <= {load_val[6:0], 1'b0};
                        end else begin
                            tx_sr    <= load_val;
                        end
                        state <= SHIFT;
                    end
                    SHIFT: begin
                        if (byte_done) begin
                            mosi_byte <= rx_sr;
                            mosi_tick <= 1'b1;
                            byte_done <= 1'b0;
                            bit_cnt   <= 4'd0;
                            state     <= LOAD;
                        end else if (sample_edge) begin
                            rx_sr     <= {rx_sr[6:0], mosi_s};
                            bit_cnt   <= bit_cnt + 4'd1;
                            byte_done <= (bit_cnt == 4'd7);
                            // underrun is flagged when a fill byte actually starts, not when
                            // the speculative LOAD after the last byte of a frame fetches it
                            underrun  <= (bit_cnt == 4'd0) && fill_pend;
                            fill_pend <= 1'b0;
                        end else if (shift_edge && (CPHA || bit_cnt != 4'd0)) begin
                            spi_miso <= tx_sr[7];
                            tx_sr    <= {tx_sr[6:0], 1'b0};
                        end
                    end
                    default: state <= WAIT_HIGH;
                endcase
            end
        end
    end
endmodule
